// File: rtl/pkt_test_pkg.sv
// Shared types and constants for the 10GbE packet-test blocks.
// Holds the sequencer state encoding, the header marker and the generator reset length.
package pkt_test_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam logic [31:0] HEADER_WORD = 32'haabbccdd;
   localparam int unsigned ARM_CYCLES  = 2;

   function automatic logic [31:0] clamp_min(input logic [31:0] v, input logic [31:0] lo);
      return (v < lo) ? lo : v;
   endfunction

endpackage

// File: rtl/pkt_framer.sv
// Registered data/valid stage with end-of-frame detection on the falling edge of valid.
// o_eof marks the last valid word: the registered word is valid and no word follows it.
module pkt_framer #(
   parameter int unsigned WIDTH = 128
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_eof
);

   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             w_valid_nxt;

   // A word only counts if the generator was enabled when it presented it.
   assign w_valid_nxt = i_valid & i_en;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_data  <= i_data;
         r_valid <= w_valid_nxt;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_eof   = r_valid & ~w_valid_nxt;

endmodule

// File: rtl/pkt_gen_ctrl.sv
// Packet-test sequencer: programs the generator, sweeps burst length over steps,
// frames generator output for the 10GbE TX core and reports run status.
module pkt_gen_ctrl
   import pkt_test_pkg::*;
#(
   parameter int unsigned DOUT_WIDTH = 32,
   parameter int unsigned PARALLEL   = 4,
   parameter int unsigned MIN_SLEEP  = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           stop,
   input  logic [31:0]                    cfg_burst_len,
   input  logic [15:0]                    cfg_burst_step,
   input  logic [7:0]                     cfg_n_steps,
   input  logic [31:0]                    cfg_n_packets,
   input  logic [31:0]                    cfg_sleep,
   output logic                           gen_rst,
   output logic                           gen_en,
   output logic [31:0]                    gen_burst_len,
   output logic [31:0]                    gen_sleep_write,
   input  logic [DOUT_WIDTH*PARALLEL-1:0] gen_dout,
   input  logic                           gen_dout_valid,
   input  logic                           tx_afull,
   output logic [DOUT_WIDTH*PARALLEL-1:0] tx_data,
   output logic                           tx_valid,
   output logic                           tx_eof,
   output logic                           busy,
   output logic                           done,
   output logic [7:0]                     step_idx,
   output logic [31:0]                    pkt_count,
   output logic                           err_afull
);

   localparam int unsigned W = DOUT_WIDTH * PARALLEL;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_arm_cnt;
   logic [7:0]  r_n_steps;
   logic [31:0] r_n_packets;
   logic [15:0] r_burst_step;
   logic [31:0] r_burst_len;
   logic [31:0] r_sleep;
   logic [7:0]  r_step_idx;
   logic [31:0] r_pkt_count;
   logic        r_err_afull;

   logic        w_gen_rst;
   logic        w_gen_en;
   logic        w_tx_valid;
   logic        w_tx_eof;
   logic        w_start_ok;
   logic        w_arm_last;
   logic [31:0] w_pkt_inc;
   logic        w_last_pkt;
   logic        w_more_steps;

   assign w_start_ok   = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));
   assign w_arm_last   = (r_arm_cnt == 2'(ARM_CYCLES - 1));
   assign w_pkt_inc    = (r_pkt_count == '1) ? r_pkt_count : r_pkt_count + 32'd1;
   assign w_last_pkt   = (w_pkt_inc == r_n_packets);
   assign w_more_steps = ({1'b0, r_step_idx} + 9'd1) < {1'b0, r_n_steps};

   pkt_framer #(
      .WIDTH (W)
   ) u_framer (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_data  (gen_dout),
      .i_valid (gen_dout_valid),
      .i_en    (w_gen_en),
      .o_data  (tx_data),
      .o_valid (w_tx_valid),
      .o_eof   (w_tx_eof)
   );

   // Generator controls are decoded apart from next-state so tx_eof (which depends on gen_en) feeds no loop.
   always_comb begin
      w_gen_rst = 1'b1;
      w_gen_en  = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_gen_rst = 1'b0;
            w_gen_en  = ~(tx_afull & ~gen_dout_valid & ~w_tx_valid);
         end
         ST_DRAIN: begin
            w_gen_rst = 1'b0;
            w_gen_en  = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) w_state_nxt = ST_ARM;
         end
         ST_ARM: begin
            if (stop)
               w_state_nxt = ST_DONE;
            else if (w_arm_last)
               w_state_nxt = (r_n_packets == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (w_tx_eof && w_last_pkt)
               w_state_nxt = w_more_steps ? ST_ARM : ST_DONE;
            else if (stop)
               w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_tx_eof || (!w_tx_valid && !gen_dout_valid)) w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_arm_cnt    <= '0;
         r_n_steps    <= 8'd1;
         r_n_packets  <= '0;
         r_burst_step <= '0;
         r_burst_len  <= '0;
         r_sleep      <= 32'(MIN_SLEEP);
         r_step_idx   <= '0;
         r_pkt_count  <= '0;
         r_err_afull  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_arm_cnt <= (r_state == ST_ARM) ? r_arm_cnt + 2'd1 : '0;

         if (w_start_ok) begin
            r_n_steps    <= (cfg_n_steps == '0) ? 8'd1 : cfg_n_steps;
            r_n_packets  <= cfg_n_packets;
            r_burst_step <= cfg_burst_step;
            r_burst_len  <= cfg_burst_len;
            r_sleep      <= clamp_min(cfg_sleep, 32'(MIN_SLEEP));
            r_step_idx   <= '0;
         end

         if (r_state == ST_ARM)
            r_pkt_count <= '0;
         else if (w_tx_eof && ((r_state == ST_RUN) || (r_state == ST_DRAIN)))
            r_pkt_count <= w_pkt_inc;

         if ((r_state == ST_RUN) && w_tx_eof && w_last_pkt && w_more_steps) begin
            r_step_idx  <= r_step_idx + 8'd1;
            r_burst_len <= r_burst_len + {16'd0, r_burst_step};
         end

         if (tx_afull && w_tx_valid) r_err_afull <= 1'b1;
      end
   end

   assign gen_rst         = w_gen_rst;
   assign gen_en          = w_gen_en;
   assign gen_burst_len   = r_burst_len;
   assign gen_sleep_write = r_sleep;
   assign tx_valid        = w_tx_valid;
   assign tx_eof          = w_tx_eof;
   assign busy            = (r_state == ST_ARM) | (r_state == ST_RUN) | (r_state == ST_DRAIN);
   assign done            = (r_state == ST_DONE);
   assign step_idx        = r_step_idx;
   assign pkt_count       = r_pkt_count;
   assign err_afull       = r_err_afull;

endmodule

// File: tb/tb_pkt_gen_ctrl.sv
// Directed bench for pkt_gen_ctrl with a behavioural packet generator and an expected-word queue.
// Every tx_valid word is popped from the queue and compared for data and eof.
module tb_pkt_gen_ctrl;
   import pkt_test_pkg::*;

   localparam int unsigned DW  = 32;
   localparam int unsigned PAR = 4;
   localparam int unsigned W   = DW * PAR;

   logic          clk = 1'b0;
   logic          rst, start, stop, tx_afull;
   logic [31:0]   cfg_burst_len, cfg_n_packets, cfg_sleep;
   logic [15:0]   cfg_burst_step;
   logic [7:0]    cfg_n_steps;
   logic          gen_rst, gen_en, gen_dout_valid;
   logic [31:0]   gen_burst_len, gen_sleep_write;
   logic [W-1:0]  gen_dout, tx_data;
   logic          tx_valid, tx_eof, busy, done, err_afull;
   logic [7:0]    step_idx;
   logic [31:0]   pkt_count;

   pkt_gen_ctrl #(
      .DOUT_WIDTH (DW),
      .PARALLEL   (PAR),
      .MIN_SLEEP  (4)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .stop            (stop),
      .cfg_burst_len   (cfg_burst_len),
      .cfg_burst_step  (cfg_burst_step),
      .cfg_n_steps     (cfg_n_steps),
      .cfg_n_packets   (cfg_n_packets),
      .cfg_sleep       (cfg_sleep),
      .gen_rst         (gen_rst),
      .gen_en          (gen_en),
      .gen_burst_len   (gen_burst_len),
      .gen_sleep_write (gen_sleep_write),
      .gen_dout        (gen_dout),
      .gen_dout_valid  (gen_dout_valid),
      .tx_afull        (tx_afull),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .tx_eof          (tx_eof),
      .busy            (busy),
      .done            (done),
      .step_idx        (step_idx),
      .pkt_count       (pkt_count),
      .err_afull       (err_afull)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] data_word(input logic [31:0] i);
      logic [W-1:0] w;
      w = '0;
      for (int k = 0; k < int'(PAR); k++) w[k*DW +: DW] = 4 * i + 32'(k);
      return w;
   endfunction

   // Generator: header, burst_len data words, then sleep_write idle cycles; frozen while gen_en=0.
   logic [1:0]  g_ph  = 2'd0;
   logic [31:0] g_cnt = 32'd0;
   always @(posedge clk) begin
      if (gen_rst === 1'b1) begin
         g_ph  <= 2'd0;
         g_cnt <= 32'd0;
      end else if (gen_en === 1'b1) begin
         case (g_ph)
            2'd0: begin
               g_cnt <= 32'd0;
               g_ph  <= (gen_burst_len == 32'd0) ? 2'd2 : 2'd1;
            end
            2'd1: begin
               if (g_cnt == gen_burst_len - 32'd1) begin
                  g_ph  <= 2'd2;
                  g_cnt <= 32'd0;
               end else g_cnt <= g_cnt + 32'd1;
            end
            default: begin
               if (g_cnt >= gen_sleep_write - 32'd1) begin
                  g_ph  <= 2'd0;
                  g_cnt <= 32'd0;
               end else g_cnt <= g_cnt + 32'd1;
            end
         endcase
      end
   end
   assign gen_dout_valid = (g_ph != 2'd2);
   assign gen_dout       = (g_ph == 2'd0) ? W'(HEADER_WORD) : data_word(g_cnt);

   typedef struct packed {
      logic [W-1:0] data;
      logic         eof;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;
   int words_seen = 0;
   int eofs_seen = 0;
   int idle_cnt = 0;
   int arm_len = 0;
   logic prev_eof = 1'b0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_pkt(input int unsigned blen);
      exp_q.push_back('{data: W'(HEADER_WORD), eof: (blen == 0)});
      for (int unsigned i = 0; i < blen; i++)
         exp_q.push_back('{data: data_word(32'(i)), eof: (i == blen - 1)});
   endtask

   task automatic sample();
      exp_t e;
      if (rst) begin
         idle_cnt = 0;
         prev_eof = 1'b0;
         arm_len  = 0;
         return;
      end
      if (busy && gen_rst) arm_len++;
      else if (arm_len != 0) begin
         check("arm_len", W'(arm_len), W'(2));
         arm_len = 0;
      end
      if (tx_valid) begin
         words_seen++;
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_word: got %0h expected no tx_valid", tx_data);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tx_data", tx_data, e.data);
            check("tx_eof", W'(tx_eof), W'(e.eof));
         end
         if (prev_eof) check("gap_ge2", W'(idle_cnt >= 2), W'(1));
         prev_eof = tx_eof;
         idle_cnt = 0;
         if (tx_eof) eofs_seen++;
      end else begin
         check("eof_without_valid", W'(tx_eof), W'(0));
         idle_cnt++;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic run_start(input logic [31:0] blen, input logic [15:0] bstep, input logic [7:0] nsteps,
                            input logic [31:0] npkts, input logic [31:0] sleep);
      cfg_burst_len  = blen;
      cfg_burst_step = bstep;
      cfg_n_steps    = nsteps;
      cfg_n_packets  = npkts;
      cfg_sleep      = sleep;
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         cycle();
         n++;
      end
      check(tag, W'(done), W'(1));
   endtask

   task automatic wait_words(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while (words_seen < target && n < budget) begin
         cycle();
         n++;
      end
      check(tag, W'(words_seen >= target), W'(1));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_gen_rst"}, W'(gen_rst), W'(1));
      check({tag, "_gen_en"}, W'(gen_en), W'(0));
      check({tag, "_burst_len"}, W'(gen_burst_len), W'(0));
      check({tag, "_sleep"}, W'(gen_sleep_write), W'(4));
      check({tag, "_tx_valid"}, W'(tx_valid), W'(0));
      check({tag, "_tx_eof"}, W'(tx_eof), W'(0));
      check({tag, "_tx_data"}, tx_data, W'(0));
      check({tag, "_busy"}, W'(busy), W'(0));
      check({tag, "_done"}, W'(done), W'(0));
      check({tag, "_step_idx"}, W'(step_idx), W'(0));
      check({tag, "_pkt_count"}, W'(pkt_count), W'(0));
      check({tag, "_err_afull"}, W'(err_afull), W'(0));
   endtask

   initial begin
      int base;
      rst = 1'b1; start = 1'b0; stop = 1'b0; tx_afull = 1'b0;
      cfg_burst_len = '0; cfg_burst_step = '0; cfg_n_steps = '0; cfg_n_packets = '0; cfg_sleep = '0;
      repeat (3) cycle();
      check_reset_values("reset");
      rst = 1'b0;
      repeat (2) cycle();

      // 1: three packets of burst 8, single step
      push_pkt(8); push_pkt(8); push_pkt(8);
      run_start(32'd8, 16'd0, 8'd1, 32'd3, 32'd10);
      check("t1_sleep", W'(gen_sleep_write), W'(10));
      wait_done("t1_done", 2000);
      check("t1_pkt_count", W'(pkt_count), W'(3));
      check("t1_step_idx", W'(step_idx), W'(0));
      check("t1_q_empty", W'(exp_q.size()), W'(0));
      check("t1_eofs", W'(eofs_seen), W'(3));

      // 2: three steps, burst 8/12/16, two packets each
      push_pkt(8); push_pkt(8); push_pkt(12); push_pkt(12); push_pkt(16); push_pkt(16);
      run_start(32'd8, 16'd4, 8'd3, 32'd2, 32'd6);
      wait_done("t2_done", 3000);
      check("t2_step_idx", W'(step_idx), W'(2));
      check("t2_burst_len", W'(gen_burst_len), W'(16));
      check("t2_pkt_count", W'(pkt_count), W'(2));
      check("t2_q_empty", W'(exp_q.size()), W'(0));

      // 3: sleep below the clamp, n_steps=0 behaves as one step
      push_pkt(2); push_pkt(2); push_pkt(2);
      run_start(32'd2, 16'd0, 8'd0, 32'd3, 32'd0);
      check("t3_sleep_clamp", W'(gen_sleep_write), W'(4));
      wait_done("t3_done", 2000);
      check("t3_pkt_count", W'(pkt_count), W'(3));
      check("t3_q_empty", W'(exp_q.size()), W'(0));

      // 4: stop on the 3rd word of packet 2
      push_pkt(8); push_pkt(8);
      base = words_seen;
      run_start(32'd8, 16'd0, 8'd1, 32'd5, 32'd10);
      wait_words("t4_reach", base + 11, 500);
      stop = 1'b1;
      cycle();
      stop = 1'b0;
      wait_done("t4_done", 500);
      repeat (30) cycle();
      check("t4_pkt_count", W'(pkt_count), W'(2));
      check("t4_still_done", W'(done), W'(1));
      check("t4_q_empty", W'(exp_q.size()), W'(0));

      // 5a: tx_afull held over the inter-packet gap
      push_pkt(4); push_pkt(4);
      base = eofs_seen;
      run_start(32'd4, 16'd0, 8'd1, 32'd2, 32'd10);
      begin
         int n;
         n = 0;
         while (eofs_seen < base + 1 && n < 500) begin
            cycle();
            n++;
         end
      end
      check("t5_first_eof", W'(eofs_seen), W'(base + 1));
      tx_afull = 1'b1;
      base = words_seen;
      repeat (20) cycle();
      check("t5_held_no_words", W'(words_seen), W'(base));
      check("t5_held_gen_en", W'(gen_en), W'(0));
      tx_afull = 1'b0;
      wait_done("t5_done", 500);
      check("t5_err_clear", W'(err_afull), W'(0));
      check("t5_pkt_count", W'(pkt_count), W'(2));
      check("t5_q_empty", W'(exp_q.size()), W'(0));

      // 5b: tx_afull pulse mid-packet
      push_pkt(8);
      base = words_seen;
      run_start(32'd8, 16'd0, 8'd1, 32'd1, 32'd5);
      wait_words("t5b_reach", base + 3, 500);
      tx_afull = 1'b1;
      cycle();
      tx_afull = 1'b0;
      wait_done("t5b_done", 500);
      check("t5b_err_set", W'(err_afull), W'(1));
      check("t5b_q_empty", W'(exp_q.size()), W'(0));

      // 6a: reset in the middle of a packet
      push_pkt(8); push_pkt(8); push_pkt(8);
      base = words_seen;
      run_start(32'd8, 16'd0, 8'd1, 32'd3, 32'd4);
      wait_words("t6_reach", base + 4, 500);
      rst = 1'b1;
      cycle();
      check_reset_values("t6_rst");
      exp_q.delete();
      rst = 1'b0;
      repeat (10) cycle();
      check("t6_idle_no_words", W'(tx_valid), W'(0));

      // 6b: zero packets goes straight through ARM to DONE
      base = words_seen;
      run_start(32'd8, 16'd0, 8'd1, 32'd0, 32'd4);
      wait_done("t6b_done", 20);
      repeat (5) cycle();
      check("t6b_no_words", W'(words_seen), W'(base));
      check("t6b_pkt_count", W'(pkt_count), W'(0));
      check("t6b_busy", W'(busy), W'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
